score_display: RTL and testbench

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display.sv | 128 ++++++++++++
 tb/tb_score_display.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// Score display: converts an 11-bit binary score to 4 BCD digits (shift-and-add-3)
// and time-multiplexes them onto an active-low 7-segment display with leading-zero blanking.
module score_display #(
  parameter int SCAN_DIV = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] count,
  output logic [15:0] bcd,
  output logic        busy,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t               state_reg, state_next;
  logic [10:0]          last_count_reg, last_count_next;
  logic [26:0]          shift_reg, shift_next;
  logic [3:0]           iter_reg, iter_next;
  logic [15:0]          bcd_reg, bcd_next;
  logic [SCAN_DIV-1:0]  scan_reg;

  logic [15:0]          adj_bcd;
  logic [26:0]          shifted;
  logic [1:0]           digit_sel;
  logic [3:0]           digit_val;
  logic [3:0]           zero_from;
  logic                 blank;

  // Add-3 correction on every BCD nibble ahead of the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign adj_bcd[4*gi +: 4] = (shift_reg[11+4*gi +: 4] >= 4'd5) ?
                                  shift_reg[11+4*gi +: 4] + 4'd3 :
                                  shift_reg[11+4*gi +: 4];
    end
  endgenerate

  assign shifted = {adj_bcd, shift_reg[10:0]} << 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_count_reg <= '0;
      shift_reg      <= '0;
      iter_reg       <= '0;
      bcd_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      last_count_reg <= last_count_next;
      shift_reg      <= shift_next;
      iter_reg       <= iter_next;
      bcd_reg        <= bcd_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_count_next = last_count_reg;
    shift_next      = shift_reg;
    iter_next       = iter_reg;
    bcd_next        = bcd_reg;
    case (state_reg)
      IDLE: begin
        if (count != last_count_reg) begin
          last_count_next = count;
          shift_next      = {16'b0, count};
          iter_next       = 4'd11;
          state_next      = CONV;
        end
      end
      CONV: begin
        shift_next = shifted;
        iter_next  = iter_reg - 4'd1;
        // Final shift: publish the whole result at once so no partial digits leak out.
        if (iter_reg == 4'd1) begin
          bcd_next   = shifted[26:11];
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bcd  = bcd_reg;
  assign busy = (state_reg == CONV);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) scan_reg <= '0;
    else      scan_reg <= scan_reg + {{(SCAN_DIV-1){1'b0}}, 1'b1};
  end

  assign digit_sel = scan_reg[SCAN_DIV-1 -: 2];
  assign an        = ~(4'b0001 << digit_sel);

  // zero_from[i]: digit i and every digit above it are zero.
  assign zero_from[0] = 1'b0;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_zero
      assign zero_from[gi] = (bcd_reg[15:4*gi] == '0);
    end
  endgenerate

  assign digit_val = bcd_reg[4*digit_sel +: 4];
  assign blank     = zero_from[digit_sel];

  always_comb begin
    seg = 8'hFF;
    if (!blank) begin
      case (digit_val)
        4'd0:    seg = 8'hC0;
        4'd1:    seg = 8'hF9;
        4'd2:    seg = 8'hA4;
        4'd3:    seg = 8'hB0;
        4'd4:    seg = 8'h99;
        4'd5:    seg = 8'h92;
        4'd6:    seg = 8'h82;
        4'd7:    seg = 8'hF8;
        4'd8:    seg = 8'h80;
        4'd9:    seg = 8'h90;
        default: seg = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: queued expected conversion results checked by a busy-edge monitor,
// plus directed checks of reset state, hold-during-conversion and scanned display output.
module tb_score_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] count;
  logic [15:0] bcd;
  logic        busy;
  logic [3:0]  an;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [3:0]  scan_model;
  logic        prev_busy = 1'b0;
  int          busy_len  = 0;

  score_display #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .bcd   (bcd),
    .busy  (busy),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) scan_model <= '0;
    else      scan_model <= scan_model + 4'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: each completed conversion (busy falling) pops one expected result.
  always @(negedge clk) begin
    if (!rst) begin
      prev_busy = 1'b0;
      busy_len  = 0;
    end else begin
      if (busy) begin
        busy_len++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {16'h0, bcd}, 32'hDEAD_DEAD);
        end else begin
          chk("conv_bcd", {16'h0, bcd}, {16'h0, exp_q.pop_front()});
        end
        chk("conv_busy_cycles", busy_len, 11);
        busy_len = 0;
      end
      prev_busy = busy;
    end
  end

  // exp_seg packs the expected segment byte for digit d at [8*d +: 8].
  task automatic check_display(input string name, input logic [31:0] exp_seg, input int n);
    logic [1:0] d;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d = scan_model[3:2];
      chk({name, "_an"},  {28'h0, an},  {28'h0, ~(4'b0001 << d)});
      chk({name, "_seg"}, {24'h0, seg}, {24'h0, exp_seg[8*d +: 8]});
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy_fall(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    rst   = 1'b0;
    count = 11'd0;
    wait_cycles(3);
    chk("rst_bcd",  {16'h0, bcd}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_an",   {28'h0, an},  32'hE);
    chk("rst_seg",  {24'h0, seg}, 32'hC0);

    rst = 1'b1;
    wait_cycles(5);
    chk("idle_zero_busy", {31'h0, busy}, 32'h0);
    chk("idle_zero_bcd",  {16'h0, bcd}, 32'h0);

    count = 11'd1234;
    exp_q.push_back(16'h1234);
    wait_cycles(5);
    chk("hold_busy", {31'h0, busy}, 32'h1);
    chk("hold_bcd",  {16'h0, bcd}, 32'h0);
    wait_cycles(10);
    check_display("d1234", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 20);

    count = 11'd2047;
    exp_q.push_back(16'h2047);
    wait_cycles(15);
    check_display("d2047", {8'hA4, 8'hC0, 8'h99, 8'hF8}, 16);

    count = 11'd5;
    exp_q.push_back(16'h0005);
    wait_cycles(15);
    check_display("d5", {8'hFF, 8'hFF, 8'hFF, 8'h92}, 16);

    count = 11'd10;
    exp_q.push_back(16'h0010);
    wait_cycles(3);
    count = 11'd11;
    exp_q.push_back(16'h0011);
    wait_busy_fall("first_of_pair");
    @(negedge clk);
    chk("gap_one_cycle", {31'h0, busy}, 32'h1);
    wait_cycles(14);
    check_display("d11", {8'hFF, 8'hFF, 8'hF9, 8'hF9}, 16);

    count = 11'd999;
    wait_cycles(7);
    rst = 1'b0;
    #1;
    chk("abort_bcd",  {16'h0, bcd}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_an",   {28'h0, an},  32'hE);
    chk("abort_seg",  {24'h0, seg}, 32'hC0);
    wait_cycles(3);
    rst = 1'b1;
    exp_q.push_back(16'h0999);
    wait_cycles(5);
    chk("restart_busy", {31'h0, busy}, 32'h1);
    chk("restart_bcd",  {16'h0, bcd}, 32'h0);
    wait_cycles(10);
    check_display("d999", {8'hFF, 8'h90, 8'h90, 8'h90}, 16);

    chk("pending_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
